// File: rtl/zspi_pkg.sv
// Shared types and constants for the ZYNQ SPI readout slave (zynq_spi_tx).
package zspi_pkg;

  localparam int         ZSPI_WIDTH    = 16;
  localparam logic [3:0] IDLE_TAG      = 4'hF;
  // Shortest legal SCLK high or low time, in CK50 cycles.
  localparam int         SCLK_MIN_HALF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    WDONE = 2'd3
  } state_t;

endpackage

// File: rtl/zynq_spi_tx_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus registered rise/fall strobes.
// Strobes appear SYNC_STAGES+1 cycles after the pin changes.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = prev_q;

endmodule

// File: rtl/zynq_spi_tx.sv
// SPI slave (CPOL=0, CPHA=0) shifting muxed readout words to the ZYNQ, MSB first.
// Optional macro ZSPI_TAG_EN replaces the low nibble of each word with a rolling sequence tag.
module zynq_spi_tx
  import zspi_pkg::*;
#(
  parameter int               WIDTH       = ZSPI_WIDTH,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD   = '0
) (
  input  logic             CK50,
  input  logic             RST,
  input  logic             RD_EN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             SCLK,
  input  logic             CS_n,
  output logic             MISO,
  output logic             SPI_done,
  output logic             frame_err,
  output logic             busy,
  output state_t           fsm_state
);

  localparam int             CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  FULL   = CW'(WIDTH);
  localparam logic [7:0]     SETTLE = 8'(SYNC_STAGES + 2);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .CLK      (CK50),
    .RST      (RST),
    .async_in (SCLK),
    .level    (sclk_level),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .CLK      (CK50),
    .RST      (RST),
    .async_in (CS_n),
    .level    (cs_level),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    bit_cnt;
  logic             reload;
  logic             word_valid;
  logic             armed;
  logic [7:0]       settle_cnt;
  logic [WIDTH-1:0] load_word;

`ifdef ZSPI_TAG_EN
  logic [3:0] seq;

  always_comb begin
    load_word      = RD_EN ? DIN : IDLE_WORD;
    load_word[3:0] = RD_EN ? seq : IDLE_TAG;
  end
`else
  always_comb begin
    load_word = RD_EN ? DIN : IDLE_WORD;
  end
`endif

  // Upstream handshake: DIN is sampled whenever a load happens and is trusted
  // only while RD_EN is high; SPI_done pulses once per completed RD_EN word and
  // the next load happens at the following SCLK fall, at least 5 cycles later.
  always_ff @(posedge CK50) begin
    if (RST) begin
      state      <= IDLE;
      sr         <= '0;
      MISO       <= 1'b0;
      busy       <= 1'b0;
      SPI_done   <= 1'b0;
      frame_err  <= 1'b0;
      bit_cnt    <= '0;
      reload     <= 1'b0;
      word_valid <= 1'b0;
      armed      <= 1'b0;
      settle_cnt <= '0;
`ifdef ZSPI_TAG_EN
      seq        <= 4'd0;
`endif
    end else begin
      SPI_done  <= 1'b0;
      frame_err <= 1'b0;

      // A select already low when reset releases must go high before it counts.
      if (!armed) begin
        if (settle_cnt != SETTLE)
          settle_cnt <= settle_cnt + 8'd1;
        else if (cs_level)
          armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          MISO    <= 1'b0;
          busy    <= 1'b0;
          bit_cnt <= '0;
          reload  <= 1'b0;
          // CPOL=0: a select edge while SCLK idles high is not a frame start.
          if (cs_fall && armed && !sclk_level)
            state <= LOAD;
        end

        LOAD: begin
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            MISO  <= 1'b0;
          end else begin
            sr         <= load_word;
            MISO       <= load_word[WIDTH-1];
            word_valid <= RD_EN;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            MISO      <= 1'b0;
            reload    <= 1'b0;
            bit_cnt   <= '0;
            frame_err <= (bit_cnt != '0);
          end else if (sclk_rise) begin
            if (bit_cnt == LAST) begin
              bit_cnt  <= FULL;
              state    <= WDONE;
              SPI_done <= word_valid;
`ifdef ZSPI_TAG_EN
              if (word_valid)
                seq <= seq + 4'd1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            if (reload) begin
              sr         <= load_word;
              MISO       <= load_word[WIDTH-1];
              word_valid <= RD_EN;
              reload     <= 1'b0;
            end else if (bit_cnt != '0) begin
              sr   <= {sr[WIDTH-2:0], 1'b0};
              MISO <= sr[WIDTH-2];
            end
          end
        end

        WDONE: begin
          bit_cnt <= '0;
          if (cs_rise) begin
            state  <= IDLE;
            busy   <= 1'b0;
            MISO   <= 1'b0;
            reload <= 1'b0;
          end else begin
            reload <= 1'b1;
            state  <= SHIFT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_zynq_spi_tx.sv
// Directed bench for zynq_spi_tx acting as the ZYNQ SPI master; honours ZSPI_TAG_EN.
module tb_zynq_spi_tx;
  import zspi_pkg::*;

  localparam int W    = 16;
  localparam int HALF = SCLK_MIN_HALF + 2;

  // clock / reset
  logic         CK50 = 1'b0;
  logic         RST  = 1'b1;
  logic         RD_EN = 1'b0;
  logic [W-1:0] DIN  = '0;
  logic         SCLK = 1'b0;
  logic         CS_n = 1'b1;
  logic         MISO, SPI_done, frame_err, busy;
  state_t       fsm_state;

  always #10 CK50 = ~CK50;

  zynq_spi_tx #(.WIDTH(W), .SYNC_STAGES(2), .IDLE_WORD(16'h0000)) dut (
    .CK50      (CK50),
    .RST       (RST),
    .RD_EN     (RD_EN),
    .DIN       (DIN),
    .SCLK      (SCLK),
    .CS_n      (CS_n),
    .MISO      (MISO),
    .SPI_done  (SPI_done),
    .frame_err (frame_err),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // scoreboard
  int           tests = 0;
  int           fails = 0;
  int           done_cnt = 0;
  int           err_cnt = 0;
  int           feed_cd = 0;
  logic [3:0]   seq_m = 4'd0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] din_feed_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_word(input logic [W-1:0] d, input logic rd);
    logic [W-1:0] w;
    w = rd ? d : 16'h0000;
`ifdef ZSPI_TAG_EN
    w[3:0] = rd ? seq_m : IDLE_TAG;
`endif
    return w;
  endfunction

  task automatic push_exp(input logic [W-1:0] d, input logic rd);
    exp_q.push_back(model_word(d, rd));
    if (rd) seq_m = seq_m + 4'd1;
  endtask

  // driver tasks: every wait passes through tick, which also counts pulses
  // and plays the upstream channel that updates DIN after each SPI_done
  task automatic tick();
    @(posedge CK50);
    #1;
    if (SPI_done)  done_cnt++;
    if (frame_err) err_cnt++;
    if (feed_cd > 0) begin
      feed_cd--;
      if (feed_cd == 0 && din_feed_q.size() > 0) DIN = din_feed_q.pop_front();
    end
    if (SPI_done) feed_cd = 2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic shift_bits(input int n, output logic [W-1:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      ticks(HALF);
      rx   = {rx[W-2:0], MISO};
      SCLK = 1'b1;
      ticks(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic run_frame(input int nwords, input string tag);
    logic [W-1:0] rx;
    CS_n = 1'b0;
    ticks(10);
    for (int w = 0; w < nwords; w++) begin
      shift_bits(W, rx);
      check($sformatf("%s_%0d", tag, w), 32'(rx), 32'(exp_q.pop_front()));
    end
    ticks(HALF);
    CS_n = 1'b1;
    ticks(12);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_miso"}, 32'(MISO), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(SPI_done), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
  endtask

  initial begin
    int           d0, e0;
    logic [W-1:0] rx, wd;

    // reset state
    ticks(4);
    check_quiet("reset");
    RST = 1'b0;
    ticks(10);

    // single word ABC0
    RD_EN = 1'b1;
    DIN   = 16'hABC0;
    push_exp(16'hABC0, 1'b1);
    d0 = done_cnt; e0 = err_cnt;
    run_frame(1, "t1_word");
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_ferr_cnt", 32'(err_cnt - e0), 32'd0);

    // three back-to-back words, DIN refreshed 2 cycles after each SPI_done
    DIN = 16'h1230;
    din_feed_q = '{16'h4560, 16'h7890};
    push_exp(16'h1230, 1'b1);
    push_exp(16'h4560, 1'b1);
    push_exp(16'h7890, 1'b1);
    d0 = done_cnt;
    run_frame(3, "t2_word");
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd3);
    check("t2_feed_used", 32'(din_feed_q.size()), 32'd0);

    // RD_EN low at frame start: idle word, no SPI_done
    RD_EN = 1'b0;
    DIN   = 16'h5550;
    push_exp(16'h5550, 1'b0);
    d0 = done_cnt;
    run_frame(1, "t3_idle");
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd0);

    // CS_n raised after 7 rising edges
    RD_EN = 1'b1;
    DIN   = 16'h5A50;
    wd    = model_word(16'h5A50, 1'b1);
    d0 = done_cnt; e0 = err_cnt;
    CS_n = 1'b0;
    ticks(10);
    shift_bits(7, rx);
    check("t4_partial", 32'(rx[6:0]), 32'(wd[15:9]));
    ticks(HALF);
    CS_n = 1'b1;
    ticks(12);
    check("t4_ferr_cnt", 32'(err_cnt - e0), 32'd1);
    check("t4_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("t4_state", 32'(fsm_state), 32'(IDLE));
    check("t4_busy", 32'(busy), 32'd0);
    push_exp(16'h5A50, 1'b1);
    run_frame(1, "t4_next");

    // reset after 5 bits with CS_n held low through release
    DIN = 16'h3C30;
    d0 = done_cnt; e0 = err_cnt;
    CS_n = 1'b0;
    ticks(10);
    shift_bits(5, rx);
    RST = 1'b1;
    tick();
    check_quiet("t5_in_reset");
    tick();
    RST   = 1'b0;
    seq_m = 4'd0;
    shift_bits(4, rx);
    check("t5_no_busy", 32'(busy), 32'd0);
    check("t5_no_miso", 32'(MISO), 32'd0);
    check("t5_state", 32'(fsm_state), 32'(IDLE));
    check("t5_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("t5_ferr_cnt", 32'(err_cnt - e0), 32'd0);
    CS_n = 1'b1;
    ticks(12);
    DIN = 16'hC3C0;
    push_exp(16'hC3C0, 1'b1);
    run_frame(1, "t5_after_reset");

    // 17 back-to-back words from a fresh reset (tags 0..15 then 0 when enabled)
    RST = 1'b1;
    ticks(2);
    RST   = 1'b0;
    seq_m = 4'd0;
    ticks(10);
    for (int i = 0; i < 17; i++) begin
      wd = {12'(i * 12'h111 + 12'h0A5), 4'h0};
      if (i == 0) DIN = wd;
      else        din_feed_q.push_back(wd);
      push_exp(wd, 1'b1);
    end
    d0 = done_cnt;
    run_frame(17, "t6_word");
    check("t6_done_cnt", 32'(done_cnt - d0), 32'd17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zynq_spi_tx.md
Name: zynq_spi_tx

Overview:
Downstream stage of the multi-channel digitizer. It takes the muxed 16-bit readout word (12-bit ADC sample, low nibble zero) and shifts it out to the ZYNQ over SPI, acting as an SPI slave. SCLK and CS_n are oversampled in the CK50 domain. The block pulses SPI_done after each completed word so the upstream channel advances its read pointer. It is a single-clock design with no async FIFO.

Parameters:
WIDTH, 16, word width shifted per transfer (MSB first)
SYNC_STAGES, 2, flip-flop stages on SCLK and CS_n (minimum 2)
IDLE_WORD, 16'h0000, word sent when RD_EN is low at load time

Ports:
CK50  input  1  system clock, 50 MHz
RST  input  1  synchronous, active-high reset
RD_EN  input  1  upstream readout enable (ZYNQ_RD_EN); DIN is valid while high
DIN  input  WIDTH  readout word from the channel mux
SCLK  input  1  SPI clock from ZYNQ, asynchronous; CPOL=0, CPHA=0
CS_n  input  1  SPI chip select from ZYNQ, active low, asynchronous
MISO  output  1  serial data to ZYNQ
SPI_done  output  1  one-CK50 pulse per completed word
frame_err  output  1  one-CK50 pulse when CS_n deasserts mid-word
busy  output  1  high while a frame is active

Behaviour:
- Synchronisation and edge detect:
  - SCLK and CS_n each pass through SYNC_STAGES flops, then a one-flop edge detector.
  - sclk_rise, sclk_fall, cs_fall and cs_rise are single-cycle strobes.
  - Strobes lag the pins by SYNC_STAGES+1 cycles.
- Timing requirement: SCLK high and low times are each at least 6 CK50 cycles, so max SCLK is about 4 MHz. Faster clocks are out of spec and their behaviour is undefined.
- FSM states: IDLE, LOAD, SHIFT, WDONE.
  - IDLE:
    - MISO=0, busy=0, bit_cnt=0.
    - cs_fall -> LOAD.
  - LOAD (1 cycle):
    - sr <= RD_EN ? DIN : IDLE_WORD.
    - MISO <= that word's MSB.
    - bit_cnt=0, busy=1 -> SHIFT.
  - SHIFT:
    - sclk_rise: bit_cnt++. When bit_cnt reaches WIDTH -> WDONE.
    - sclk_fall with bit_cnt in 1..WIDTH-1: sr <= sr<<1; MISO <= new MSB.
    - A sclk_fall when bit_cnt=0 is ignored (spurious edge).
  - WDONE (1 cycle):
    - SPI_done=1 -> SHIFT with bit_cnt=0 and reload pending.
    - The next sclk_fall with reload pending performs a LOAD from DIN/RD_EN instead of a shift.
    - This gives upstream at least 5 CK50 cycles after SPI_done to present the next word.
- CS_n rise:
  - From any non-IDLE state -> IDLE.
  - If 0 < bit_cnt < WIDTH, pulse frame_err and do not pulse SPI_done.
  - If the rise coincides with the WDONE cycle, WDONE completes (SPI_done=1) and the FSM then goes to IDLE.
- RD_EN dropping mid-word: the word in flight completes unchanged and SPI_done still pulses. The next load uses IDLE_WORD.
- SPI_done is asserted only in WDONE, never for IDLE_WORD loads made while RD_EN=0; that word's WDONE is suppressed.
- Reset outputs: MISO=0, SPI_done=0, frame_err=0, busy=0, sr=0, FSM=IDLE, synchronisers cleared to SCLK=0 and CS_n=1.
  - Reset mid-frame aborts silently with no frame_err.
  - After reset release, a frame starts only on a fresh cs_fall; a CS_n already low at release is ignored until it goes high again.

Optional Feature:
Macro ZSPI_TAG_EN.
- Defined: at each load the low 4 bits of the shifted word are replaced by a 4-bit rolling sequence counter seq.
  - seq resets to 0 and increments after each SPI_done, wrapping 15->0.
  - IDLE_WORD loads carry the tag 4'hF and do not increment seq.
  - This lets the ZYNQ detect dropped words.
- Undefined: DIN or IDLE_WORD is shifted unmodified; no seq register exists.

Decomposition:
- Package zspi_pkg holds:
  - the FSM state enum (IDLE, LOAD, SHIFT, WDONE)
  - WIDTH default
  - the IDLE_TAG constant 4'hF
  - the minimum SCLK half-period constant 6 for bench checks
- One natural sub-module: sync_edge, a SYNC_STAGES synchroniser plus rise/fall strobe generator. It is instantiated twice, for SCLK and CS_n.

Test Plan:
- Reset, then CS_n low with RD_EN=1, DIN=16'hABC0, 16 SCLK at 8-cycle half-period -> MISO bits 1010101111000000 sampled on rising edges; one SPI_done; frame_err=0.
- Three back-to-back words with DIN updated 2 cycles after each SPI_done (16'h1230, 16'h4560, 16'h7890) -> ZYNQ receives all three in order; exactly 3 SPI_done pulses.
- RD_EN=0 at frame start -> MISO shifts 16'h0000 (tag 4'hF under ZSPI_TAG_EN); no SPI_done.
- CS_n raised after 7 rising edges -> one frame_err pulse, no SPI_done, FSM in IDLE; the next frame starts cleanly from bit 15.
- RST asserted after 5 bits -> all outputs 0 the next cycle; CS_n held low through release gives no activity until a CS_n high-low cycle.
- With ZSPI_TAG_EN, 17 words with DIN low nibble 0 -> tags 0..15 then 0; upper 12 bits match DIN.
